pe_opsum_collector: RTL and testbench

Receiving end of the PE control interface. Sits beside each MAC PE and its controller. It samples the three active-low select lines and the PE output word. On every output-psum cycle it captures the PE result into a small FIFO, then presents the results downstream on a valid/ready stream. It also checks the control sequence and flags any protocol errors. The PE cannot stall, so a full FIFO drops data and sets a sticky flag.

---
 rtl/pe_opsum_collector.sv | 155 +++++++++++++++
 tb/tb_pe_opsum_collector.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_opsum_collector.sv
// pe_opsum_collector
//   Sits beside a MAC PE and its controller. Watches the active-low select
//   lines, captures the PE result on every output-psum cycle into a small
//   FIFO, and streams the results downstream on valid/ready. The PE cannot
//   stall, so a push into a full FIFO (without a simultaneous pop) is dropped.
//   A checker FSM verifies that each output is preceded by exactly
//   kernel_size OP cycles.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   mult_seln         1 = ipsum path, 0 = multiplier path
//   acc_seln          1 = zero into accumulator, 0 = feedback psum
//   opsum_seln        0 = PE output valid this cycle
//   kernel_size       MACs per output (0 means 256)
//   opsum_data        PE accumulator output
//   err_clr           clears both sticky flags
//   m_data/m_valid    head-of-FIFO psum / FIFO non-empty
//   m_ready           downstream accept
//   level             FIFO occupancy
//   out_count         psums accepted into the FIFO (wraps)
//   overflow          sticky: a psum was dropped
//   proto_err         sticky: illegal select sequence seen
module pe_opsum_collector #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mult_seln,
    input  logic                     acc_seln,
    input  logic                     opsum_seln,
    input  logic [7:0]               kernel_size,
    input  logic [DATA_W-1:0]        opsum_data,
    input  logic                     err_clr,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         out_count,
    output logic                     overflow,
    output logic                     proto_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [0:0] ChkWait = 1'b0;
    localparam logic [0:0] ChkRun  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [8:0]        run_cnt_q, run_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q, perr_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [2:0] code;
    logic       is_opsum;
    logic       perr_set;
    logic [8:0] exp_run;
    logic       full;
    logic       pop;
    logic       push_ok;
    logic       ovf_set;

    assign code     = {mult_seln, acc_seln, opsum_seln};
    assign is_opsum = (code == 3'b000);
    assign exp_run  = (kernel_size == 8'd0) ? 9'd256 : {1'b0, kernel_size};

    // Checker FSM: counts OP cycles and validates the count at each OPSUM.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        perr_set  = 1'b0;
        case (code)
            3'b001: begin
                if (state_q == ChkWait) begin
                    state_d   = ChkRun;
                    run_cnt_d = 9'd1;
                end else if (run_cnt_q != 9'd511) begin
                    run_cnt_d = run_cnt_q + 9'd1;
                end
            end
            3'b111: begin
                // IPSUM in the middle of a run aborts the run.
                if (state_q == ChkRun) begin
                    perr_set  = 1'b1;
                    state_d   = ChkWait;
                    run_cnt_d = 9'd0;
                end
            end
            3'b000: begin
                if (state_q == ChkWait || run_cnt_q != exp_run) begin
                    perr_set = 1'b1;
                end
                state_d   = ChkWait;
                run_cnt_d = 9'd0;
            end
            default: begin
                perr_set  = 1'b1;
                state_d   = ChkWait;
                run_cnt_d = 9'd0;
            end
        endcase
    end

    // FIFO control. A full FIFO still accepts a push when it pops in the
    // same cycle; the popped entry is read before the slot is overwritten.
    assign full    = (level_q == LVL_W'(DEPTH));
    assign m_valid = (level_q != '0);
    assign pop     = m_valid && m_ready;
    assign push_ok = is_opsum && (!full || pop);
    assign ovf_set = is_opsum && full && !pop;
    assign level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ChkWait;
            run_cnt_q <= 9'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            perr_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            level_q   <= level_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= opsum_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                cnt_q           <= cnt_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            // A new error in the clearing cycle keeps the flag set.
            ovf_q  <= ovf_set  | (ovf_q  & ~err_clr);
            perr_q <= perr_set | (perr_q & ~err_clr);
        end
    end

    assign m_data    = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign out_count = cnt_q;
    assign overflow  = ovf_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_pe_opsum_collector.sv
// tb_pe_opsum_collector
//   Directed bench for pe_opsum_collector (DATA_W=16, DEPTH=4, CNT_W=16).
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   at the same point, i.e. after the edge that sampled the stimulus.
module tb_pe_opsum_collector;

    logic        clk;
    logic        rst;
    logic        mult_seln, acc_seln, opsum_seln;
    logic [7:0]  kernel_size;
    logic [15:0] opsum_data;
    logic        err_clr;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  level;
    logic [15:0] out_count;
    logic        overflow;
    logic        proto_err;

    int tests = 0;
    int fails = 0;

    localparam logic [2:0] IDLE  = 3'b111;
    localparam logic [2:0] OP    = 3'b001;
    localparam logic [2:0] OPSUM = 3'b000;

    pe_opsum_collector #(
        .DATA_W(16),
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mult_seln  (mult_seln),
        .acc_seln   (acc_seln),
        .opsum_seln (opsum_seln),
        .kernel_size(kernel_size),
        .opsum_data (opsum_data),
        .err_clr    (err_clr),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .level      (level),
        .out_count  (out_count),
        .overflow   (overflow),
        .proto_err  (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc(input logic [2:0] code, input logic [15:0] d);
        {mult_seln, acc_seln, opsum_seln} = code;
        opsum_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        {mult_seln, acc_seln, opsum_seln} = IDLE;
        kernel_size = 8'd3;
        opsum_data  = 16'h0;
        err_clr     = 1'b0;
        m_ready     = 1'b1;

        // Reset state
        cyc(IDLE, 16'h0);
        cyc(IDLE, 16'h0);
        rst = 1'b0;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'h0);
        chk("rst_cnt", 32'(out_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_perr", 32'(proto_err), 32'd0);

        // Normal run, kernel_size=3
        cyc(IDLE, 16'h0);
        cyc(OP, 16'h0);
        cyc(OP, 16'h0);
        cyc(OP, 16'h0);
        cyc(OPSUM, 16'h1234);
        chk("norm_valid", 32'(m_valid), 32'd1);
        chk("norm_data", 32'(m_data), 32'h1234);
        chk("norm_cnt", 32'(out_count), 32'd1);
        chk("norm_perr", 32'(proto_err), 32'd0);
        chk("norm_level", 32'(level), 32'd1);
        cyc(IDLE, 16'h0);
        chk("norm_popped", 32'(m_valid), 32'd0);

        // Short run: two OPs for kernel_size=3
        m_ready = 1'b0;
        cyc(OP, 16'h0);
        cyc(OP, 16'h0);
        cyc(OPSUM, 16'hABCD);
        chk("short_perr", 32'(proto_err), 32'd1);
        chk("short_cnt", 32'(out_count), 32'd2);
        chk("short_data", 32'(m_data), 32'hABCD);
        err_clr = 1'b1;
        m_ready = 1'b1;
        cyc(IDLE, 16'h0);
        err_clr = 1'b0;
        chk("short_clr", 32'(proto_err), 32'd0);
        chk("short_level", 32'(level), 32'd0);

        // Overflow: five pushes into a 4-deep FIFO
        kernel_size = 8'd1;
        m_ready = 1'b0;
        for (int d = 1; d <= 5; d++) begin
            cyc(OP, 16'h0);
            cyc(OPSUM, 16'(d));
        end
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(out_count), 32'd6);
        chk("ovf_perr", 32'(proto_err), 32'd0);
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_drain", 32'(m_data), 32'(i));
            cyc(IDLE, 16'h0);
        end
        chk("ovf_empty", 32'(m_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        err_clr = 1'b1;
        cyc(IDLE, 16'h0);
        err_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Full FIFO with a pop in the same cycle as the push
        m_ready = 1'b0;
        for (int d = 0; d < 4; d++) begin
            cyc(OP, 16'h0);
            cyc(OPSUM, 16'h11 + 16'(d));
        end
        chk("fp_full", 32'(level), 32'd4);
        cyc(OP, 16'h0);
        m_ready = 1'b1;
        cyc(OPSUM, 16'h15);
        chk("fp_level", 32'(level), 32'd4);
        chk("fp_ovf", 32'(overflow), 32'd0);
        chk("fp_cnt", 32'(out_count), 32'd11);
        for (int i = 0; i < 4; i++) begin
            chk("fp_order", 32'(m_data), 32'h12 + 32'(i));
            cyc(IDLE, 16'h0);
        end
        chk("fp_empty", 32'(level), 32'd0);

        // kernel_size=0 means 256 OPs
        kernel_size = 8'd0;
        for (int i = 0; i < 256; i++) cyc(OP, 16'h0);
        cyc(OPSUM, 16'h0256);
        chk("k256_perr", 32'(proto_err), 32'd0);
        chk("k256_data", 32'(m_data), 32'h0256);
        chk("k256_cnt", 32'(out_count), 32'd12);
        for (int i = 0; i < 255; i++) cyc(OP, 16'h0);
        cyc(OPSUM, 16'h0255);
        chk("k255_perr", 32'(proto_err), 32'd1);
        chk("k255_cnt", 32'(out_count), 32'd13);
        err_clr = 1'b1;
        cyc(IDLE, 16'h0);
        err_clr = 1'b0;
        chk("k255_clr", 32'(proto_err), 32'd0);
        chk("k_empty", 32'(level), 32'd0);

        // Illegal code, error vs. clear priority, IPSUM mid-run
        kernel_size = 8'd1;
        cyc(3'b011, 16'h0);
        chk("ill_perr", 32'(proto_err), 32'd1);
        chk("ill_nocap", 32'(out_count), 32'd13);
        err_clr = 1'b1;
        cyc(3'b010, 16'h0);
        chk("clr_vs_err", 32'(proto_err), 32'd1);
        cyc(IDLE, 16'h0);
        err_clr = 1'b0;
        chk("clr_ok", 32'(proto_err), 32'd0);
        cyc(OP, 16'h0);
        cyc(IDLE, 16'h0);
        chk("ipsum_mid", 32'(proto_err), 32'd1);
        err_clr = 1'b1;
        cyc(IDLE, 16'h0);
        err_clr = 1'b0;

        // Reset mid-operation
        m_ready = 1'b0;
        cyc(OP, 16'h0);
        cyc(OPSUM, 16'h00A1);
        cyc(OP, 16'h0);
        cyc(OPSUM, 16'h00A2);
        cyc(3'b110, 16'h0);
        cyc(OP, 16'h0);
        chk("mid_level", 32'(level), 32'd2);
        chk("mid_cnt", 32'(out_count), 32'd15);
        chk("mid_perr", 32'(proto_err), 32'd1);
        rst = 1'b1;
        cyc(OP, 16'h0);
        rst = 1'b0;
        chk("mrst_level", 32'(level), 32'd0);
        chk("mrst_valid", 32'(m_valid), 32'd0);
        chk("mrst_cnt", 32'(out_count), 32'd0);
        chk("mrst_data", 32'(m_data), 32'h0);
        chk("mrst_perr", 32'(proto_err), 32'd0);
        chk("mrst_ovf", 32'(overflow), 32'd0);

        // OPSUM directly after reset: error, but still captured
        cyc(OPSUM, 16'h0077);
        chk("post_perr", 32'(proto_err), 32'd1);
        chk("post_cnt", 32'(out_count), 32'd1);
        chk("post_data", 32'(m_data), 32'h0077);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
